// File: rtl/usb_cmd_rx_if.sv
// usb_cmd_rx_if -- FT232H 245-sync FIFO read side plus the usb_data bus
// arbitration handshake shared with the upload path.
//   usb_data_in : byte from the FT232H (valid while n_OE is low)
//   n_RXF       : low while the FT232H holds unread bytes
//   n_RD, n_OE  : active-low read strobe / output enable
//   bus_req     : request for the shared usb_data bus
//   bus_gnt     : grant from usb_control
// master = command receiver, slave = FT232H / arbiter side.
interface usb_cmd_rx_if;
  logic [7:0] usb_data_in;
  logic       n_RXF;
  logic       n_RD;
  logic       n_OE;
  logic       bus_req;
  logic       bus_gnt;

  modport master (input usb_data_in, n_RXF, bus_gnt, output n_RD, n_OE, bus_req);
  modport slave  (output usb_data_in, n_RXF, bus_gnt, input n_RD, n_OE, bus_req);
endinterface

// File: rtl/usb_cmd_rx.sv
// usb_cmd_rx -- host-to-device command receiver on the FT232H 245-sync link.
// Reads frames [SYNC][cmd][d3][d2][d1][d0][cs] (cs = xor of cmd..d0), decodes
// them into the receiver control registers. Optional feature macro
// MICRON_CMD_CSUM_EN: when undefined, frames are 6 bytes with no checksum
// and are applied on the d0 byte.
// Ports:
//   usb_clock, m_reset : 60 MHz clock, synchronous active-high reset
//   bus                : usb_cmd_rx_if.master (FT232H read + bus req/gnt)
//   rx_freq, att, rx_rate, rx_on, bs_on, bs_period : control registers
//   cmd_stb            : one-cycle pulse when a frame has been applied
//   err_cnt            : saturating count of bad/timed-out frames
module usb_cmd_rx #(
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter int unsigned TIMEOUT_CYC = 60000,
  parameter logic [31:0] FREQ_DEF    = 32'd7_100_000,
  parameter logic [7:0]  RATE_DEF    = 8'd1
) (
  input  logic         usb_clock,
  input  logic         m_reset,
  usb_cmd_rx_if.master bus,
  output logic [31:0]  rx_freq,
  output logic [7:0]   att,
  output logic [7:0]   rx_rate,
  output logic         rx_on,
  output logic         bs_on,
  output logic [7:0]   bs_period,
  output logic         cmd_stb,
  output logic [7:0]   err_cnt
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {B_IDLE, B_REQ, B_OE, B_READ, B_REL} bus_st_e;
  typedef enum logic [2:0] {P_HDR, P_CMD, P_D3, P_D2, P_D1, P_D0, P_CS} prs_st_e;

  bus_st_e bus_q, bus_d;
  prs_st_e prs_q, prs_d;
  logic [7:0]    cmd_q, cmd_d, csum_q, csum_d;
  logic [31:0]   dat_q, dat_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          n_rd, n_oe, req, take, apply, bad;
  logic [31:0]   word;

  logic [31:0] freq_q;
  logic [7:0]  att_q, rate_q, per_q, err_q;
  logic        on_q, bs_q, stb_q;

  // ---------------- state registers ----------------
  always_ff @(posedge usb_clock) begin
    if (m_reset) begin
      bus_q  <= B_IDLE;
      prs_q  <= P_HDR;
      cmd_q  <= '0;
      csum_q <= '0;
      dat_q  <= '0;
      tmo_q  <= '0;
    end else begin
      bus_q  <= bus_d;
      prs_q  <= prs_d;
      cmd_q  <= cmd_d;
      csum_q <= csum_d;
      dat_q  <= dat_d;
      tmo_q  <= tmo_d;
    end
  end

  // ---------------- bus FSM ----------------
  always_comb begin
    bus_d = bus_q;
    n_rd  = 1'b1;
    n_oe  = 1'b1;
    req   = 1'b0;
    case (bus_q)
      B_IDLE: if (!bus.n_RXF) bus_d = B_REQ;
      B_REQ: begin
        req = 1'b1;
        if (bus.bus_gnt) bus_d = B_OE;
      end
      B_OE: begin
        // one cycle of n_OE before n_RD falls; bail out if grant was lost
        req   = 1'b1;
        n_oe  = 1'b0;
        bus_d = bus.bus_gnt ? B_READ : B_REL;
      end
      B_READ: begin
        req  = 1'b1;
        n_oe = 1'b0;
        n_rd = 1'b0;
        if (bus.n_RXF || !bus.bus_gnt) bus_d = B_REL;
      end
      B_REL:   bus_d = B_IDLE;
      default: bus_d = B_IDLE;
    endcase
  end

  assign bus.n_RD    = n_rd;
  assign bus.n_OE    = n_oe;
  assign bus.bus_req = req;

  // a byte is consumed on every edge with n_RD and n_RXF both low
  assign take = (bus_q == B_READ) && !bus.n_RXF;

  // ---------------- frame parser ----------------
  // Parser state survives bus release, so a frame may span bursts.
  always_comb begin
    prs_d  = prs_q;
    cmd_d  = cmd_q;
    csum_d = csum_q;
    dat_d  = dat_q;
    tmo_d  = tmo_q;
    apply  = 1'b0;
    bad    = 1'b0;
    word   = dat_q;
    if (take) begin
      // a byte on the timeout cycle takes priority over the timeout
      tmo_d = '0;
      case (prs_q)
        P_HDR: if (bus.usb_data_in == SYNC_BYTE) prs_d = P_CMD;
        P_CMD: begin
          cmd_d  = bus.usb_data_in;
          csum_d = bus.usb_data_in;
          prs_d  = P_D3;
        end
        P_D3, P_D2, P_D1: begin
          dat_d  = {dat_q[23:0], bus.usb_data_in};
          csum_d = csum_q ^ bus.usb_data_in;
          prs_d  = (prs_q == P_D3) ? P_D2 : (prs_q == P_D2) ? P_D1 : P_D0;
        end
`ifdef MICRON_CMD_CSUM_EN
        P_D0: begin
          dat_d  = {dat_q[23:0], bus.usb_data_in};
          csum_d = csum_q ^ bus.usb_data_in;
          prs_d  = P_CS;
        end
        P_CS: begin
          if (bus.usb_data_in == csum_q) apply = 1'b1;
          else                           bad   = 1'b1;
          prs_d = P_HDR;
        end
`else
        P_D0: begin
          dat_d = {dat_q[23:0], bus.usb_data_in};
          word  = {dat_q[23:0], bus.usb_data_in};
          apply = 1'b1;
          prs_d = P_HDR;
        end
`endif
        default: prs_d = P_HDR;
      endcase
    end else if (prs_q != P_HDR) begin
      if (tmo_q == TMO_LAST) begin
        bad   = 1'b1;
        prs_d = P_HDR;
        tmo_d = '0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  // ---------------- control registers ----------------
  always_ff @(posedge usb_clock) begin
    if (m_reset) begin
      freq_q <= FREQ_DEF;
      att_q  <= '0;
      rate_q <= RATE_DEF;
      on_q   <= 1'b0;
      bs_q   <= 1'b0;
      per_q  <= '0;
      stb_q  <= 1'b0;
      err_q  <= '0;
    end else begin
      stb_q <= apply;
      if (bad && err_q != 8'hFF) err_q <= err_q + 8'd1;
      if (apply) begin
        case (cmd_q)
          8'h01: freq_q <= word;
          8'h02: att_q  <= word[7:0];
          8'h03: rate_q <= word[7:0];
          8'h04: begin
            on_q <= word[0];
            bs_q <= word[1];
          end
          8'h05: per_q <= word[7:0];
          default: ;
        endcase
      end
    end
  end

  assign rx_freq   = freq_q;
  assign att       = att_q;
  assign rx_rate   = rate_q;
  assign rx_on     = on_q;
  assign bs_on     = bs_q;
  assign bs_period = per_q;
  assign cmd_stb   = stb_q;
  assign err_cnt   = err_q;
endmodule

// File: tb/tb_usb_cmd_rx.sv
`timescale 1ns/1ps
module tb_usb_cmd_rx;
  localparam int TMO = 200;
`ifdef MICRON_CMD_CSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic usb_clock = 1'b0;
  logic m_reset;
  always #5 usb_clock = ~usb_clock;

  usb_cmd_rx_if bus();
  logic [31:0] rx_freq;
  logic [7:0]  att, rx_rate, bs_period, err_cnt;
  logic        rx_on, bs_on, cmd_stb;

  usb_cmd_rx #(.TIMEOUT_CYC(TMO)) dut (
    .usb_clock(usb_clock), .m_reset(m_reset), .bus(bus),
    .rx_freq(rx_freq), .att(att), .rx_rate(rx_rate), .rx_on(rx_on),
    .bs_on(bs_on), .bs_period(bs_period), .cmd_stb(cmd_stb), .err_cnt(err_cnt)
  );

  typedef struct packed {
    logic [31:0] freq;
    logic [7:0]  att;
    logic [7:0]  rate;
    logic        on;
    logic        bs;
    logic [7:0]  per;
    logic [7:0]  err;
  } regs_t;

  regs_t mdl, dut_r;
  assign dut_r = {rx_freq, att, rx_rate, rx_on, bs_on, bs_period, err_cnt};

  int tests = 0, fails = 0;
  int stb_seen = 0, exp_stb = 0;

  // ---- FT232H byte source: drives n_RXF/data, pops on each consumed byte ----
  logic [7:0] q[$];
  bit take_pend = 1'b0;
  always @(negedge usb_clock) begin
    if (take_pend && q.size() > 0) void'(q.pop_front());
    bus.n_RXF       = (q.size() == 0);
    bus.usb_data_in = (q.size() > 0) ? q[0] : 8'h00;
    take_pend       = (bus.n_RD === 1'b0) && (bus.n_RXF == 1'b0);
  end

  always @(negedge usb_clock) if (cmd_stb === 1'b1) stb_seen++;

  // ---- reference model: register effect of a frame by command rules ----
  task automatic model_reset();
    mdl = '{freq: 32'd7_100_000, att: 8'd0, rate: 8'd1, on: 1'b0, bs: 1'b0, per: 8'd0, err: 8'd0};
  endtask

  task automatic model_apply(input logic [7:0] c, input logic [31:0] d);
    case (c)
      8'h01: mdl.freq = d;
      8'h02: mdl.att  = d[7:0];
      8'h03: mdl.rate = d[7:0];
      8'h04: begin mdl.on = d[0]; mdl.bs = d[1]; end
      8'h05: mdl.per  = d[7:0];
      default: ;
    endcase
    exp_stb++;
  endtask

  task automatic model_err();
    if (mdl.err != 8'd255) mdl.err = mdl.err + 8'd1;
  endtask

  // ---- stimulus helpers ----
  task automatic push_frame(input logic [7:0] c, input logic [31:0] d, input bit cs_ok);
    logic [7:0] cs;
    q.push_back(8'hA5);
    q.push_back(c);
    for (int i = 3; i >= 0; i--) q.push_back(d[i*8 +: 8]);
    cs = c ^ d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0];
    if (!cs_ok) cs = cs ^ 8'($urandom_range(1, 255));
    if (CSUM) q.push_back(cs);
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || bus.bus_req !== 1'b0) && n < 2000) begin
      @(negedge usb_clock); #1; n++;
    end
    repeat (3) @(negedge usb_clock);
    #1;
    tests++;
    if (n >= 2000) begin
      fails++;
      $display("FAIL drain: bytes left %0d, required 0 within 2000 cycles", q.size());
    end
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [31:0] d, input bit cs_ok, input bit gap);
    push_frame(c, d, cs_ok);
    if (gap) begin
      repeat ($urandom_range(1, 8)) @(negedge usb_clock);
      #2 bus.bus_gnt = 1'b0;
      repeat ($urandom_range(1, 60)) @(negedge usb_clock);
      #2 bus.bus_gnt = 1'b1;
    end
    drain();
    if (cs_ok || !CSUM) model_apply(c, d);
    else                model_err();
  endtask

  // ---- scenarios ----
  task automatic test_reset();
    m_reset = 1'b1;
    repeat (3) @(negedge usb_clock);
    m_reset = 1'b0;
    model_reset();
    repeat (5) @(negedge usb_clock);
    #1;
    tests++;
    if (dut_r !== mdl) begin fails++; $display("FAIL reset_regs: got %h want %h", dut_r, mdl); end
    tests++;
    if ({bus.n_RD, bus.n_OE, bus.bus_req, cmd_stb} !== 4'b1100) begin
      fails++;
      $display("FAIL reset_bus: got nRD/nOE/req/stb=%b want 1100", {bus.n_RD, bus.n_OE, bus.bus_req, cmd_stb});
    end
  endtask

  task automatic test_freq_frame();
    int oe_fall = -1, rd_fall = -1, stb0;
    stb0 = stb_seen;
    push_frame(8'h01, 32'h00E4E1C0, 1'b1);
    for (int i = 0; i < 40; i++) begin
      @(negedge usb_clock); #1;
      if (oe_fall < 0 && bus.n_OE === 1'b0) oe_fall = i;
      if (rd_fall < 0 && bus.n_RD === 1'b0) rd_fall = i;
    end
    drain();
    model_apply(8'h01, 32'h00E4E1C0);
    tests++;
    if (oe_fall < 0 || rd_fall - oe_fall != 1) begin
      fails++;
      $display("FAIL oe_before_rd: nOE fell at %0d, nRD at %0d, required gap 1", oe_fall, rd_fall);
    end
    tests++;
    if (rx_freq !== 32'h00E4E1C0) begin fails++; $display("FAIL freq_frame: got %h want 00e4e1c0", rx_freq); end
    tests++;
    if (stb_seen - stb0 != 1) begin fails++; $display("FAIL freq_stb: got %0d pulses want 1", stb_seen - stb0); end
  endtask

  task automatic test_ctrl_frame();
    send_frame(8'h04, 32'h00000003, 1'b1, 1'b0);
    tests++;
    if ({rx_on, bs_on} !== 2'b11) begin fails++; $display("FAIL ctrl_frame: got on/bs=%b want 11", {rx_on, bs_on}); end
`ifdef MICRON_CMD_CSUM_EN
    q.push_back(8'hA5); q.push_back(8'h04); q.push_back(8'h00); q.push_back(8'h00);
    q.push_back(8'h00); q.push_back(8'h00); q.push_back(8'h00);
    drain();
    model_err();
    tests++;
    if (dut_r !== mdl) begin fails++; $display("FAIL bad_cs: got %h want %h", dut_r, mdl); end
    send_frame(8'h01, 32'h12345678, 1'b0, 1'b0);
    tests++;
    if (dut_r !== mdl) begin fails++; $display("FAIL bad_cs_freq: got %h want %h", dut_r, mdl); end
`endif
    tests++;
    if (stb_seen != exp_stb) begin fails++; $display("FAIL ctrl_stb: got %0d want %0d", stb_seen, exp_stb); end
  endtask

  task automatic test_gnt_gap();
    int len, n = 0;
    logic [31:0] d;
    d = {24'h0, 8'($urandom_range(2, 250))};
    push_frame(8'h03, d, 1'b1);
    len = q.size();
    while (q.size() > len - 4 && n < 200) begin @(negedge usb_clock); #1; n++; end
    bus.bus_gnt = 1'b0;
    @(negedge usb_clock); #1;
    tests++;
    if (bus.n_RD !== 1'b1) begin fails++; $display("FAIL gnt_drop_rd: got nRD=%b want 1", bus.n_RD); end
    repeat (100) @(negedge usb_clock);
    #1;
    tests++;
    if ({bus.n_RD, bus.n_OE} !== 2'b11) begin
      fails++; $display("FAIL gnt_hold: got nRD/nOE=%b want 11", {bus.n_RD, bus.n_OE});
    end
    bus.bus_gnt = 1'b1;
    drain();
    model_apply(8'h03, d);
    tests++;
    if (dut_r !== mdl) begin fails++; $display("FAIL gnt_gap_frame: got %h want %h", dut_r, mdl); end
  endtask

  task automatic test_timeout();
    q.push_back(8'hA5); q.push_back(8'h02); q.push_back(8'h11); q.push_back(8'h22); q.push_back(8'h33);
    drain();
    repeat (TMO + 10) @(negedge usb_clock);
    model_err();
    #1;
    tests++;
    if (err_cnt !== mdl.err) begin fails++; $display("FAIL timeout_err: got %0d want %0d", err_cnt, mdl.err); end
    send_frame(8'h02, 32'h0000000A, 1'b1, 1'b0);
    tests++;
    if (att !== 8'h0A || dut_r !== mdl) begin fails++; $display("FAIL post_timeout: got %h want %h", dut_r, mdl); end
    // pause well short of the limit inside a frame: frame must survive
    q.push_back(8'hA5); q.push_back(8'h05); q.push_back(8'h00); q.push_back(8'h00);
    drain();
    repeat (TMO - 40) @(negedge usb_clock);
    q.push_back(8'h00); q.push_back(8'h07);
    if (CSUM) q.push_back(8'h05 ^ 8'h07);
    drain();
    model_apply(8'h05, 32'h00000007);
    tests++;
    if (dut_r !== mdl) begin fails++; $display("FAIL short_pause: got %h want %h", dut_r, mdl); end
  endtask

  task automatic test_reset_mid();
    q.push_back(8'hA5); q.push_back(8'h01); q.push_back(8'hDE); q.push_back(8'hAD);
    drain();
    m_reset = 1'b1;
    repeat (2) @(negedge usb_clock);
    m_reset = 1'b0;
    model_reset();
    #1;
    tests++;
    if (dut_r !== mdl) begin fails++; $display("FAIL reset_mid: got %h want %h", dut_r, mdl); end
    send_frame(8'h01, 32'hCAFE1234, 1'b1, 1'b0);
    tests++;
    if (dut_r !== mdl) begin fails++; $display("FAIL after_reset_frame: got %h want %h", dut_r, mdl); end
  endtask

  task automatic test_random();
    logic [7:0] c, j;
    logic [31:0] d;
    bit ok, gap;
    for (int k = 0; k < 40; k++) begin
      repeat ($urandom_range(0, 2)) begin
        j = 8'($urandom_range(0, 255));
        if (j == 8'hA5) j = 8'h5A;
        q.push_back(j);
      end
      c = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(1, 5));
      d = $urandom;
      ok = ($urandom_range(0, 3) != 0);
      gap = ($urandom_range(0, 2) == 0);
      send_frame(c, d, ok, gap);
      tests++;
      if (dut_r !== mdl) begin fails++; $display("FAIL random[%0d] cmd %h: got %h want %h", k, c, dut_r, mdl); end
    end
    tests++;
    if (stb_seen != exp_stb) begin fails++; $display("FAIL random_stb: got %0d want %0d", stb_seen, exp_stb); end
  endtask

  task automatic test_err_sat();
    while (mdl.err != 8'd255) begin
`ifdef MICRON_CMD_CSUM_EN
      send_frame(8'h02, $urandom, 1'b0, 1'b0);
`else
      q.push_back(8'hA5);
      drain();
      repeat (TMO) @(negedge usb_clock);
      model_err();
`endif
    end
    q.push_back(8'hA5); q.push_back(8'h03);
    drain();
    repeat (TMO + 10) @(negedge usb_clock);
    model_err();
    #1;
    tests++;
    if (err_cnt !== 8'd255 || dut_r !== mdl) begin
      fails++; $display("FAIL err_sat: got %h want %h", dut_r, mdl);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    m_reset     = 1'b1;
    bus.bus_gnt = 1'b1;
    model_reset();
    test_reset();
    test_freq_frame();
    test_ctrl_frame();
    test_gnt_gap();
    test_timeout();
    test_reset_mid();
    test_random();
    test_err_sat();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
